// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD read controller: FSM state encoding,
// default timing constants and the busy-flag bit position.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HIGH,
    ST_HOLD,
    ST_FIN
  } lcd_state_t;

  localparam int LCD_DEFAULT_CLOCK_DIVIDER = 16;
  localparam int LCD_DEFAULT_SETUP_CYCLES  = 1;
  localparam int LCD_DEFAULT_HOLD_CYCLES   = 1;
  localparam int LCD_DEFAULT_POLL_LIMIT    = 255;

  // Bit 7 of a status read (RS=0) is the controller's busy flag.
  localparam int LCD_BUSY_BIT = 7;

  // Width of the shared phase counter.
  localparam int LCD_CNT_W = 5;

endpackage

// File: rtl/lcd_reader_if.sv
// Request/response and LCD bus signals of the LCD read controller.
// With LCD_READ_BUSY_POLL_EN defined the poll request and timeout flag
// are added to the bundle.
interface lcd_reader_if;

  logic       iRS;
  logic       start;
  logic [7:0] data;
  logic       done;
  logic       busy;
  logic [7:0] LCD_DATA_IN;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;
`ifdef LCD_READ_BUSY_POLL_EN
  logic       poll;
  logic       timeout;

  modport master (
    output iRS, start, LCD_DATA_IN, poll,
    input  data, done, busy, LCD_RW, LCD_EN, LCD_RS, timeout
  );

  modport slave (
    input  iRS, start, LCD_DATA_IN, poll,
    output data, done, busy, LCD_RW, LCD_EN, LCD_RS, timeout
  );
`else
  modport master (
    output iRS, start, LCD_DATA_IN,
    input  data, done, busy, LCD_RW, LCD_EN, LCD_RS
  );

  modport slave (
    input  iRS, start, LCD_DATA_IN,
    output data, done, busy, LCD_RW, LCD_EN, LCD_RS
  );
`endif

endinterface

// File: rtl/lcd_cycle_timer.sv
// Phase timer shared by the SETUP, EN_HIGH and HOLD states. Counts up from
// zero while enabled and flags expiry when the count reaches the terminal
// value (phase length minus one). Saturates instead of wrapping.
module lcd_cycle_timer
  import lcd_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 count_en,
  input  logic [LCD_CNT_W-1:0] terminal,
  output logic                 expire
);

  logic [LCD_CNT_W-1:0] count_reg;

  // Clear on reset or phase change, otherwise count up without wrapping.
  always_ff @(posedge clock) begin
    if (reset || load) begin
      count_reg <= '0;
    end else if (count_en && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = count_en && (count_reg == terminal);

endmodule

// File: rtl/lcd_reader.sv
// HD44780-style LCD read controller: on a start edge it drives RS/RW,
// strobes EN for CLOCK_DIVIDER+1 cycles, captures the bus as EN falls and
// reports completion with done.
// Optional feature macro: LCD_READ_BUSY_POLL_EN (busy-flag polling with
// poll input and timeout output).
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int CLOCK_DIVIDER = LCD_DEFAULT_CLOCK_DIVIDER,
  parameter int SETUP_CYCLES  = LCD_DEFAULT_SETUP_CYCLES,
  parameter int HOLD_CYCLES   = LCD_DEFAULT_HOLD_CYCLES,
  parameter int POLL_LIMIT    = LCD_DEFAULT_POLL_LIMIT
) (
  input  logic clock,
  input  logic reset,
  lcd_reader_if.slave bus
);

  // Reject timings the 5-bit phase counter cannot represent.
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || HOLD_CYCLES < 1 || HOLD_CYCLES > 15 ||
      CLOCK_DIVIDER < 0 || CLOCK_DIVIDER > 31 || POLL_LIMIT < 1) begin : g_param_check
    $error("lcd_reader: timing parameter out of range");
  end

  localparam logic [LCD_CNT_W-1:0] SETUP_T = LCD_CNT_W'(SETUP_CYCLES - 1);
  localparam logic [LCD_CNT_W-1:0] EN_T    = LCD_CNT_W'(CLOCK_DIVIDER);
  localparam logic [LCD_CNT_W-1:0] HOLD_T  = LCD_CNT_W'(HOLD_CYCLES - 1);

  lcd_state_t state_reg;
  logic       start_prev_reg;
  logic       start_armed_reg;
  logic [7:0] data_reg;
  logic       done_reg;
  logic       busy_reg;
  logic       lcd_rw_reg;
  logic       lcd_en_reg;
  logic       lcd_rs_reg;

  logic                 start_edge;
  logic                 state_change;
  logic                 timer_run;
  logic                 timer_expire;
  logic [LCD_CNT_W-1:0] timer_terminal;

`ifdef LCD_READ_BUSY_POLL_EN
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  logic              poll_mode_reg;
  logic              timeout_reg;
  logic [POLL_W-1:0] reads_reg;
  logic              last_read;

  assign last_read   = (reads_reg >= POLL_W'(POLL_LIMIT - 1));
  assign bus.timeout = timeout_reg;
`endif

  // The armed flag keeps a start held high through reset release from
  // looking like a fresh edge: start must be seen low first.
  assign start_edge   = bus.start && !start_prev_reg && start_armed_reg && (state_reg == ST_IDLE);
  assign state_change = start_edge || timer_expire || (state_reg == ST_FIN);

  // Select the phase length for the timed states.
  always_comb begin
    timer_run      = 1'b0;
    timer_terminal = '0;
    unique case (state_reg)
      ST_SETUP:   begin timer_run = 1'b1; timer_terminal = SETUP_T; end
      ST_EN_HIGH: begin timer_run = 1'b1; timer_terminal = EN_T;    end
      ST_HOLD:    begin timer_run = 1'b1; timer_terminal = HOLD_T;  end
      default:    ;
    endcase
  end

  lcd_cycle_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (state_change),
    .count_en (timer_run),
    .terminal (timer_terminal),
    .expire   (timer_expire)
  );

  // Read sequencer with registered LCD strobes and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      start_prev_reg  <= 1'b0;
      start_armed_reg <= 1'b0;
      data_reg        <= 8'h00;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      lcd_rw_reg      <= 1'b0;
      lcd_en_reg      <= 1'b0;
      lcd_rs_reg      <= 1'b0;
`ifdef LCD_READ_BUSY_POLL_EN
      poll_mode_reg   <= 1'b0;
      timeout_reg     <= 1'b0;
      reads_reg       <= '0;
`endif
    end else begin
      start_prev_reg  <= bus.start;
      start_armed_reg <= start_armed_reg || !bus.start;
      unique case (state_reg)
        ST_IDLE: begin
          if (start_edge) begin
            state_reg  <= ST_SETUP;
            lcd_rw_reg <= 1'b1;
            busy_reg   <= 1'b1;
            done_reg   <= 1'b0;
`ifdef LCD_READ_BUSY_POLL_EN
            // Polling always reads the status register.
            lcd_rs_reg    <= bus.poll ? 1'b0 : bus.iRS;
            poll_mode_reg <= bus.poll;
            timeout_reg   <= 1'b0;
            reads_reg     <= '0;
`else
            lcd_rs_reg <= bus.iRS;
`endif
          end
        end
        ST_SETUP: begin
          if (timer_expire) begin
            state_reg  <= ST_EN_HIGH;
            lcd_en_reg <= 1'b1;
          end
        end
        ST_EN_HIGH: begin
          if (timer_expire) begin
            state_reg  <= ST_HOLD;
            lcd_en_reg <= 1'b0;
            data_reg   <= bus.LCD_DATA_IN;
          end
        end
        ST_HOLD: begin
          if (timer_expire) begin
`ifdef LCD_READ_BUSY_POLL_EN
            if (poll_mode_reg && data_reg[LCD_BUSY_BIT] && !last_read) begin
              state_reg <= ST_SETUP;
              reads_reg <= reads_reg + 1'b1;
            end else begin
              state_reg   <= ST_FIN;
              lcd_rw_reg  <= 1'b0;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              timeout_reg <= poll_mode_reg && data_reg[LCD_BUSY_BIT];
            end
`else
            state_reg  <= ST_FIN;
            lcd_rw_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
`endif
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data   = data_reg;
  assign bus.done   = done_reg;
  assign bus.busy   = busy_reg;
  assign bus.LCD_RW = lcd_rw_reg;
  assign bus.LCD_EN = lcd_en_reg;
  assign bus.LCD_RS = lcd_rs_reg;

endmodule
